// File: rtl/pmp_gate.sv
// pmp_gate: PMP check stage in front of the data RAM.
// A request is latched, checked against four PMP entries, then forwarded to the RAM or faulted locally.
module pmp_gate #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              ifetch_i,
  input  logic              priv_m_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic              fault_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ack_i,
  input  logic              csr_we_i,
  input  logic [11:0]       csr_waddr_i,
  input  logic [31:0]       csr_wdata_i,
  input  logic [11:0]       csr_raddr_i,
  output logic [31:0]       csr_rdata_o
);
  localparam int AW = ADDR_W - 2;
  typedef enum logic [1:0] {IDLE, CHECK, ACCESS} state_t;
  state_t              r_state;
  logic [7:0]          r_cfg [ENTRIES];
  logic [AW-1:0]       r_pa  [ENTRIES];
  logic                r_we, r_if, r_pm, r_ready, r_ack, r_fault, r_ram_req, r_ram_we;
  logic [ADDR_W-1:0]   r_addr, r_ram_addr;
  logic [DATA_W-1:0]   r_data, r_rdata, r_ram_data;
  logic [AW-1:0]       w_w;
  logic [ENTRIES-1:0]  w_match, w_alock;
  logic                w_hit, w_perm, w_allow;
  logic [7:0]          w_sel;
  assign w_w = r_addr[ADDR_W-1:2];
  for (genvar i = 0; i < ENTRIES; i++) begin : g_e
    logic [AW-1:0] w_lo, w_m;
    logic [1:0]    w_a;
    assign w_a  = r_cfg[i][4:3];
    assign w_lo = (i == 0) ? '0 : r_pa[(i + ENTRIES - 1) % ENTRIES];
    assign w_m  = r_pa[i] ^ (r_pa[i] + 1'b1);
    // An empty TOR range (lo >= hi) cannot satisfy lo <= w < hi, so no extra test is needed.
    assign w_match[i] = (w_a == 2'd1) ? (w_lo <= w_w && w_w < r_pa[i]) :
                        (w_a == 2'd2) ? (w_w == r_pa[i]) :
                        (w_a == 2'd3) ? ((w_w & ~w_m) == (r_pa[i] & ~w_m)) : 1'b0;
    assign w_alock[i] = r_cfg[i][7] | ((i < ENTRIES - 1) && r_cfg[(i + 1) % ENTRIES][7] &&
                                       r_cfg[(i + 1) % ENTRIES][4:3] == 2'd1);
  end
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_sel = r_cfg[i];
      end
  end
  assign w_perm  = r_if ? w_sel[2] : r_we ? w_sel[1] : w_sel[0];
  assign w_allow = !(r_if && r_we) && (w_hit ? ((r_pm && !w_sel[7]) || w_perm) : r_pm);
  assign csr_rdata_o = (csr_raddr_i == 12'h3A0) ? {r_cfg[3], r_cfg[2], r_cfg[1], r_cfg[0]} :
                       (csr_raddr_i[11:2] == 10'h0EC) ? 32'(r_pa[csr_raddr_i[1:0]]) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cfg[i] <= '0;
        r_pa[i]  <= '0;
      end
    end else if (csr_we_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (csr_waddr_i == 12'h3A0 && !r_cfg[i][7]) r_cfg[i] <= csr_wdata_i[8*i +: 8] & 8'h9F;
        if (csr_waddr_i == {10'h0EC, 2'(i)} && !w_alock[i]) r_pa[i] <= csr_wdata_i[AW-1:0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b1;
      r_ack      <= 1'b0;
      r_fault    <= 1'b0;
      r_rdata    <= '0;
      r_ram_req  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_we       <= 1'b0;
      r_if       <= 1'b0;
      r_pm       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: if (req_i) begin
          r_we    <= we_i;
          r_if    <= ifetch_i;
          r_pm    <= priv_m_i;
          r_addr  <= addr_i;
          r_data  <= data_i;
          r_ready <= 1'b0;
          r_state <= CHECK;
        end
        CHECK: if (w_allow) begin
          r_ram_req  <= 1'b1;
          r_ram_we   <= r_we;
          r_ram_addr <= r_addr;
          r_ram_data <= r_data;
          r_state    <= ACCESS;
        end else begin
          r_ack   <= 1'b1;
          r_fault <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        ACCESS: if (ram_ack_i) begin
          r_ram_req <= 1'b0;
          r_ram_we  <= 1'b0;
          r_ack     <= 1'b1;
          r_rdata   <= r_we ? '0 : ram_data_i;
          r_ready   <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ready_o    = r_ready;
  assign ack_o      = r_ack;
  assign fault_o    = r_fault;
  assign rdata_o    = r_rdata;
  assign ram_req_o  = r_ram_req;
  assign ram_we_o   = r_ram_we;
  assign ram_addr_o = r_ram_addr;
  assign ram_data_o = r_ram_data;
endmodule

// File: tb/tb_pmp_gate.sv
// tb_pmp_gate: table-driven check of pmp_gate decisions and latency, plus lock and reset sequences.
module tb_pmp_gate;
  logic        clk = 0, rst = 0;
  logic        req_i = 0, we_i = 0, ifetch_i = 0, priv_m_i = 0;
  logic [31:0] addr_i = 0, data_i = 0, rdata_o, ram_addr_o, ram_data_o, ram_data_i = 0;
  logic        ready_o, ack_o, fault_o, ram_req_o, ram_we_o, ram_ack_i = 0, csr_we_i = 0;
  logic [11:0] csr_waddr_i = 0, csr_raddr_i = 0;
  logic [31:0] csr_wdata_i = 0, csr_rdata_o;
  int          passed = 0, total = 0;
  int          g_lat, g_reqc, g_extra;
  logic        g_fault, g_rwe;
  logic [31:0] g_rdata, g_raddr, g_rdat;
  pmp_gate dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .ifetch_i(ifetch_i), .priv_m_i(priv_m_i),
    .addr_i(addr_i), .data_i(data_i), .ready_o(ready_o), .ack_o(ack_o), .fault_o(fault_o),
    .rdata_o(rdata_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i), .csr_we_i(csr_we_i),
    .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i), .csr_raddr_i(csr_raddr_i),
    .csr_rdata_o(csr_rdata_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] cfg, a0, a1;
    logic        we, fe, pm;
    logic [31:0] addr, data, rval;
    int          wt;
    logic        fault;
  } vec_t;
  vec_t v [17];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask
  task automatic do_rst();
    @(negedge clk);
    rst = 1; req_i = 0; ram_ack_i = 0; csr_we_i = 0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic csr_w(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we_i = 1; csr_waddr_i = a; csr_wdata_i = d;
    @(negedge clk);
    csr_we_i = 0;
  endtask
  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_raddr_i = a;
    #1 chk(nm, csr_rdata_o, exp);
  endtask
  task automatic txn(input logic we, input logic fe, input logic pm, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rv, input int wt);
    int acc = 0;
    g_lat = -1; g_fault = 0; g_rdata = 0; g_reqc = 0; g_raddr = 0; g_rwe = 0; g_rdat = 0; g_extra = 0;
    @(negedge clk);
    req_i = 1; we_i = we; ifetch_i = fe; priv_m_i = pm; addr_i = a; data_i = d; ram_data_i = rv;
    @(posedge clk);
    #1 req_i = 0;
    for (int n = 1; n < 20; n++) begin
      if (ram_req_o) begin
        g_reqc++; g_raddr = ram_addr_o; g_rwe = ram_we_o; g_rdat = ram_data_o;
      end
      ram_ack_i = ram_req_o && acc == wt;
      if (ram_req_o) acc++;
      if (ack_o) begin
        g_lat = n; g_fault = fault_o; g_rdata = rdata_o;
        break;
      end
      req_i = wt > 0 && !ready_o && n % 2 == 1;
      @(posedge clk);
      #1;
    end
    req_i = 0; ram_ack_i = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1 if (ack_o || ram_req_o) g_extra++;
    end
  endtask
  initial begin
    v[0]  = '{32'h0,    32'h0,        32'h0,        0, 0, 0, 32'h100,      32'h0,        32'h0,        0, 1};
    v[1]  = '{32'h1B,   32'h43,       32'h0,        1, 0, 0, 32'h11C,      32'hDEADBEEF, 32'h0,        0, 0};
    v[2]  = '{32'h1B,   32'h43,       32'h0,        1, 0, 0, 32'h120,      32'h1,        32'h0,        0, 1};
    v[3]  = '{32'h0900, 32'h40,       32'h80,       0, 0, 0, 32'h1FC,      32'h0,        32'h12345678, 0, 0};
    v[4]  = '{32'h0900, 32'h40,       32'h80,       0, 0, 0, 32'h200,      32'h0,        32'h12345678, 0, 1};
    v[5]  = '{32'h0900, 32'h40,       32'h80,       1, 0, 0, 32'h100,      32'h2,        32'h0,        0, 1};
    v[6]  = '{32'h0900, 32'h40,       32'h80,       0, 0, 0, 32'hFC,       32'h0,        32'h0,        0, 1};
    v[7]  = '{32'h0900, 32'h40,       32'h80,       0, 0, 0, 32'h1FC,      32'h0,        32'hA5A5A5A5, 3, 0};
    v[8]  = '{32'h0,    32'h0,        32'h0,        0, 0, 1, 32'h100,      32'h0,        32'hCAFEF00D, 0, 0};
    v[9]  = '{32'h0,    32'h0,        32'h0,        1, 1, 1, 32'h100,      32'h3,        32'h0,        0, 1};
    v[10] = '{32'h14,   32'h50,       32'h0,        0, 1, 0, 32'h140,      32'h0,        32'h00000013, 0, 0};
    v[11] = '{32'h14,   32'h50,       32'h0,        0, 0, 0, 32'h140,      32'h0,        32'h0,        0, 1};
    v[12] = '{32'h19,   32'hFFFFFFFF, 32'h0,        0, 0, 0, 32'hFFFFFFFC, 32'h0,        32'h11112222, 0, 0};
    v[13] = '{32'h1B19, 32'h43,       32'h3FFFFFFF, 1, 0, 0, 32'h104,      32'h4,        32'h0,        0, 1};
    v[14] = '{32'h1B19, 32'h43,       32'h3FFFFFFF, 1, 0, 0, 32'h200,      32'h55AA,     32'h0,        0, 0};
    v[15] = '{32'h0900, 32'h80,       32'h40,       0, 0, 0, 32'h100,      32'h0,        32'h0,        0, 1};
    v[16] = '{32'h1B,   32'h43,       32'h0,        1, 0, 1, 32'h300,      32'h77,       32'h0,        1, 0};
    do_rst();
    chk("reset_ready", {31'b0, ready_o}, 1);
    chk("reset_ack", {31'b0, ack_o}, 0);
    chk("reset_ram_req", {31'b0, ram_req_o}, 0);
    rd("reset_cfg", 12'h3A0, 0);
    for (int k = 0; k < 17; k++) begin
      do_rst();
      csr_w(12'h3B0, v[k].a0);
      csr_w(12'h3B1, v[k].a1);
      csr_w(12'h3A0, v[k].cfg);
      txn(v[k].we, v[k].fe, v[k].pm, v[k].addr, v[k].data, v[k].rval, v[k].wt);
      chk($sformatf("v%0d_latency", k), g_lat, v[k].fault ? 2 : 3 + v[k].wt);
      chk($sformatf("v%0d_fault", k), {31'b0, g_fault}, {31'b0, v[k].fault});
      chk($sformatf("v%0d_rdata", k), g_rdata, (v[k].fault || v[k].we) ? 32'h0 : v[k].rval);
      chk($sformatf("v%0d_ram_req_cycles", k), g_reqc, v[k].fault ? 0 : v[k].wt + 1);
      chk($sformatf("v%0d_extra_ack", k), g_extra, 0);
      if (!v[k].fault) begin
        chk($sformatf("v%0d_ram_addr", k), g_raddr, v[k].addr);
        chk($sformatf("v%0d_ram_we", k), {31'b0, g_rwe}, {31'b0, v[k].we});
        if (v[k].we) chk($sformatf("v%0d_ram_data", k), g_rdat, v[k].data);
      end
    end
    do_rst();
    csr_w(12'h3B0, 32'h43);
    csr_w(12'h3B1, 32'h10);
    csr_w(12'h3A0, 32'h9C);
    rd("lock_cfg", 12'h3A0, 32'h9C);
    csr_w(12'h3B0, 32'h55);
    rd("lock_addr0", 12'h3B0, 32'h43);
    csr_w(12'h3A0, 32'h00600100);
    rd("lock_cfg_partial", 12'h3A0, 32'h0000019C);
    csr_w(12'h3A0, 32'h00880100);
    rd("lock_cfg2_tor", 12'h3A0, 32'h0088019C);
    csr_w(12'h3B1, 32'h99);
    rd("lock_addr1_tor", 12'h3B1, 32'h10);
    csr_w(12'h3B3, 32'hFFFFFFFF);
    rd("addr3_mask", 12'h3B3, 32'h3FFFFFFF);
    rd("unmapped", 12'h3A1, 32'h0);
    txn(0, 0, 1, 32'h104, 0, 32'h1, 0);
    chk("lock_m_load_fault", {31'b0, g_fault}, 1);
    chk("lock_m_load_lat", g_lat, 2);
    txn(0, 1, 1, 32'h104, 0, 32'h13579BDF, 0);
    chk("lock_m_fetch_fault", {31'b0, g_fault}, 0);
    chk("lock_m_fetch_rdata", g_rdata, 32'h13579BDF);
    do_rst();
    rd("lock_cleared_cfg", 12'h3A0, 0);
    rd("lock_cleared_addr", 12'h3B0, 0);
    csr_w(12'h3B0, 32'h43);
    @(negedge clk);
    req_i = 1; we_i = 0; ifetch_i = 0; priv_m_i = 1; addr_i = 32'h100;
    @(posedge clk);
    #1 req_i = 0;
    @(posedge clk);
    #1 chk("mid_ram_req_before", {31'b0, ram_req_o}, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 chk("mid_ram_req", {31'b0, ram_req_o}, 0);
    chk("mid_ready", {31'b0, ready_o}, 1);
    chk("mid_ack", {31'b0, ack_o}, 0);
    @(negedge clk);
    rst = 0;
    g_extra = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1 if (ack_o || ram_req_o) g_extra++;
    end
    chk("mid_no_ack", g_extra, 0);
    rd("mid_csr", 12'h3B0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
